regfile_rw: RTL and testbench
=============================

# regfile_rw

Register file with pending-load scoreboard for the multistage pipeline datapath. It accepts the write-back stream at the WB end: the selected destination register (the $31 override for link instructions is already applied upstream) and the selected write data (ALU result, memory data, or link PC). It serves the two ID-stage read ports that feed the ID/EX register and the ALUSrc selection. It also tracks registers with an outstanding load and raises a load-use stall to ID.

## Interface
Parameters:
- DEPTH, 32, number of architectural registers (address width fixed at 5).
- WIDTH, 32, data width.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rs_addr  input  5  read port 1 address (instr[25:21]).
- rt_addr  input  5  read port 2 address (instr[20:16]).
- out1  output  32  read port 1 data.
- out2  output  32  read port 2 data.
- wr_en  input  1  RegWrite from MEM/WB.
- wr_addr  input  5  final write-back register.
- wr_data  input  32  final write-back data.
- issue_valid  input  1  instruction leaving ID this cycle.
- issue_load  input  1  issuing instruction is a load (MemtoReg).
- issue_dst  input  5  issuing instruction's destination (RegDst-selected).
- stall  output  1  load-use hazard; ID must hold and issue a bubble.
- pending  output  32  scoreboard bit vector, bit n = register n has a load outstanding.

## Operation
- Storage: 32 x 32 flops. Register 0 reads 0 always; writes to address 0 are discarded.
- Write: on rising clk, if wr_en and wr_addr != 0, reg[wr_addr] <= wr_data.
- Read: combinational. out1 = reg[rs_addr], out2 = reg[rt_addr]; address 0 forces 0.
- Scoreboard set: on rising clk, if issue_valid, issue_load, stall == 0 and issue_dst != 0, set pending[issue_dst].
- Scoreboard clear: on rising clk, if wr_en, clear pending[wr_addr].
- Set and clear of the same register in one cycle: set wins, because the newer load is still outstanding.
- issue_valid is ignored while stall is 1. No scoreboard change comes from ID in that cycle.
- stall = (pending[rs_addr] and not cleared_now(rs_addr)) or (pending[rt_addr] and not cleared_now(rt_addr)).
  - cleared_now(a) = wr_en and wr_addr == a and a != 0.
  - Without bypass (see Configuration), cleared_now is forced to 0.
- pending[0] is never set.

## Timing
- Reset (rst_n low, asynchronous): all registers 0, pending = 0, stall = 0, out1 = out2 = 0. Release is synchronous to the next rising clk.
- Write latency: data written at edge N is visible on the read ports after edge N. With bypass, it is visible in the same cycle before edge N.
- Scoreboard latency: a load issued at edge N sets pending after edge N. A dependent instruction in ID during cycle N+1 sees stall = 1.
- stall is purely combinational from the addresses, pending, and the write port. It has no registered latency.
- Reset asserted mid-stall: stall drops immediately and all pending entries are lost.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Write-through. If wr_en, wr_addr == rs_addr (or rt_addr) and the address != 0, out1 (or out2) = wr_data in the same cycle.
  - A same-cycle write-back clears the stall term for that address.
- REGFILE_BYPASS_EN undefined:
  - Reads return the stored value only.
  - stall stays asserted for the cycle in which the write-back occurs.
  - Load-use costs one extra bubble.

## Test plan
- Reset: drive rst_n low mid-cycle with random contents and pending = 32'h0000_0100 -> out1 = out2 = 0, pending = 0, stall = 0 immediately.
- Write/read and $0: write 32'hDEAD_BEEF to reg 8, then 32'h1234_5678 to reg 0; read rs = 8, rt = 0 -> out1 = 32'hDEAD_BEEF, out2 = 0.
- Bypass: wr_en = 1, wr_addr = 9, wr_data = 32'hA5A5_A5A5, rs_addr = 9 in the same cycle.
  - With REGFILE_BYPASS_EN: out1 = 32'hA5A5_A5A5 before the edge.
  - Without: out1 = old value, and the new value appears after the edge.
- Load-use: issue load to reg 10 at edge N; in cycle N+1, rt_addr = 10 -> stall = 1, and an issue_valid in that cycle is ignored. Write-back of reg 10 at edge N+3 -> pending[10] = 0 and stall deasserts.
  - With bypass: stall deasserts in cycle N+3.
  - Without bypass: stall deasserts in cycle N+4.
- Simultaneous set/clear: pending[12] = 1; in one cycle, wr_en to 12 and a new load issued to 12 -> pending[12] remains 1 after the edge.
- $0 load: issue load with issue_dst = 0, then read rs = 0 -> pending = 0, stall = 0.

Source files
------------

// File: rtl/regfile_rw_if.sv
// Bus bundle between the ID/WB pipeline stages and the register file.
// The master side drives addresses, write-back and issue info; the slave (regfile_rw) returns read data and hazard info.
interface regfile_rw_if #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32
);
  logic [4:0]       rs_addr;
  logic [4:0]       rt_addr;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             issue_valid;
  logic             issue_load;
  logic [4:0]       issue_dst;
  logic             stall;
  logic [DEPTH-1:0] pending;

  modport master (
    output rs_addr, rt_addr, wr_en, wr_addr, wr_data,
    output issue_valid, issue_load, issue_dst,
    input  out1, out2, stall, pending
  );

  modport slave (
    input  rs_addr, rt_addr, wr_en, wr_addr, wr_data,
    input  issue_valid, issue_load, issue_dst,
    output out1, out2, stall, pending
  );
endinterface

// File: rtl/regfile_rw.sv
// Register file with a pending-load scoreboard that raises the load-use stall to ID.
// Optional macro REGFILE_BYPASS_EN: write-through on reads and same-cycle stall release on write-back.
module regfile_rw #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_rw_if.slave  bus
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;

  logic             wr_live;
  logic             rs_clr;
  logic             rt_clr;
  logic             stall;
  logic             issue_set;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;

  assign wr_live = bus.wr_en && (bus.wr_addr != 5'd0);

  // A write-back in flight this cycle both forwards its data and retires the pending load.
`ifdef REGFILE_BYPASS_EN
  assign rs_clr = wr_live && (bus.wr_addr == bus.rs_addr);
  assign rt_clr = wr_live && (bus.wr_addr == bus.rt_addr);
`else
  assign rs_clr = 1'b0;
  assign rt_clr = 1'b0;
`endif

  assign stall = (pending_q[bus.rs_addr] && !rs_clr) ||
                 (pending_q[bus.rt_addr] && !rt_clr);

  assign issue_set = bus.issue_valid && bus.issue_load && !stall &&
                     (bus.issue_dst != 5'd0);

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (bus.rs_addr != 5'd0) rd1 = regs_q[bus.rs_addr];
    if (bus.rt_addr != 5'd0) rd2 = regs_q[bus.rt_addr];
    if (rs_clr) rd1 = bus.wr_data;
    if (rt_clr) rd2 = bus.wr_data;
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_live) regs_d[bus.wr_addr] = bus.wr_data;
  end

  // Clear first, then set: a newer load to the same register stays outstanding.
  always_comb begin
    pending_d = pending_q;
    if (bus.wr_en) pending_d[bus.wr_addr] = 1'b0;
    if (issue_set) pending_d[bus.issue_dst] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  assign bus.out1    = rd1;
  assign bus.out2    = rd2;
  assign bus.stall   = stall;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_regfile_rw.sv
// Directed self-checking bench for regfile_rw; expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_rw;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  regfile_rw_if #(.DEPTH(32), .WIDTH(32)) bus ();

  regfile_rw #(.DEPTH(32), .WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rs_addr     = 5'd0;
    bus.rt_addr     = 5'd0;
    bus.wr_en       = 1'b0;
    bus.wr_addr     = 5'd0;
    bus.wr_data     = 32'h0;
    bus.issue_valid = 1'b0;
    bus.issue_load  = 1'b0;
    bus.issue_dst   = 5'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #12;
    tests++; if (bus.out1 !== 32'h0) begin fails++; $display("FAIL reset_out1 got=%h exp=%h", bus.out1, 32'h0); end
    tests++; if (bus.out2 !== 32'h0) begin fails++; $display("FAIL reset_out2 got=%h exp=%h", bus.out2, 32'h0); end
    tests++; if (bus.pending !== 32'h0) begin fails++; $display("FAIL reset_pending got=%h exp=%h", bus.pending, 32'h0); end
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=%b", bus.stall, 1'b0); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd8; bus.wr_data = 32'hDEAD_BEEF;
    tick();
    bus.wr_addr = 5'd0; bus.wr_data = 32'h1234_5678;
    tick();
    bus.wr_en = 1'b0;
    bus.rs_addr = 5'd8; bus.rt_addr = 5'd0;
    #1;
    tests++; if (bus.out1 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_rd_out1 got=%h exp=%h", bus.out1, 32'hDEAD_BEEF); end
    tests++; if (bus.out2 !== 32'h0) begin fails++; $display("FAIL wr_rd_r0 got=%h exp=%h", bus.out2, 32'h0); end
    bus.rs_addr = 5'd0; bus.rt_addr = 5'd8;
    #1;
    tests++; if (bus.out2 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_rd_out2 got=%h exp=%h", bus.out2, 32'hDEAD_BEEF); end
    idle_inputs();
    tick();
  endtask

  task automatic test_bypass();
    logic [31:0] exp_v;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h1111_1111;
    tick();
    bus.wr_data = 32'hA5A5_A5A5; bus.rs_addr = 5'd9; bus.rt_addr = 5'd0;
    #1;
    exp_v = BYP ? 32'hA5A5_A5A5 : 32'h1111_1111;
    tests++; if (bus.out1 !== exp_v) begin fails++; $display("FAIL bypass_same_cycle got=%h exp=%h", bus.out1, exp_v); end
    tests++; if (bus.out2 !== 32'h0) begin fails++; $display("FAIL bypass_other_port got=%h exp=%h", bus.out2, 32'h0); end
    tick();
    bus.wr_en = 1'b0;
    #1;
    tests++; if (bus.out1 !== 32'hA5A5_A5A5) begin fails++; $display("FAIL bypass_after_edge got=%h exp=%h", bus.out1, 32'hA5A5_A5A5); end
    // A write to $0 must never forward.
    bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hFFFF_FFFF; bus.rs_addr = 5'd0;
    #1;
    tests++; if (bus.out1 !== 32'h0) begin fails++; $display("FAIL bypass_r0 got=%h exp=%h", bus.out1, 32'h0); end
    idle_inputs();
    tick();
  endtask

  task automatic test_load_use();
    logic exp_s;
    logic [31:0] exp_o;
    bus.issue_valid = 1'b1; bus.issue_load = 1'b1; bus.issue_dst = 5'd10;
    #1;
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL lu_pre_stall got=%b exp=%b", bus.stall, 1'b0); end
    tick();                                       // edge N
    bus.issue_dst = 5'd11; bus.rt_addr = 5'd10;   // cycle N+1, issue must be ignored
    #1;
    tests++; if (bus.pending !== 32'h0000_0400) begin fails++; $display("FAIL lu_pending_set got=%h exp=%h", bus.pending, 32'h0000_0400); end
    tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL lu_stall_n1 got=%b exp=%b", bus.stall, 1'b1); end
    tick();                                       // edge N+1
    bus.issue_valid = 1'b0; bus.issue_load = 1'b0; bus.issue_dst = 5'd0;
    #1;
    tests++; if (bus.pending !== 32'h0000_0400) begin fails++; $display("FAIL lu_issue_ignored got=%h exp=%h", bus.pending, 32'h0000_0400); end
    tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL lu_stall_n2 got=%b exp=%b", bus.stall, 1'b1); end
    tick();                                       // edge N+2
    bus.wr_en = 1'b1; bus.wr_addr = 5'd10; bus.wr_data = 32'hCAFE_F00D;
    #1;
    exp_s = BYP ? 1'b0 : 1'b1;
    exp_o = BYP ? 32'hCAFE_F00D : 32'h0;
    tests++; if (bus.stall !== exp_s) begin fails++; $display("FAIL lu_stall_n3 got=%b exp=%b", bus.stall, exp_s); end
    tests++; if (bus.out2 !== exp_o) begin fails++; $display("FAIL lu_out2_n3 got=%h exp=%h", bus.out2, exp_o); end
    tick();                                       // edge N+3
    bus.wr_en = 1'b0;
    #1;
    tests++; if (bus.pending !== 32'h0) begin fails++; $display("FAIL lu_pending_clr got=%h exp=%h", bus.pending, 32'h0); end
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL lu_stall_n4 got=%b exp=%b", bus.stall, 1'b0); end
    tests++; if (bus.out2 !== 32'hCAFE_F00D) begin fails++; $display("FAIL lu_out2_n4 got=%h exp=%h", bus.out2, 32'hCAFE_F00D); end
    idle_inputs();
    tick();
  endtask

  task automatic test_set_clear();
    bus.issue_valid = 1'b1; bus.issue_load = 1'b1; bus.issue_dst = 5'd12;
    tick();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd12; bus.wr_data = 32'h0000_0C0C;
    tick();
    bus.issue_valid = 1'b0; bus.issue_load = 1'b0;
    #1;
    tests++; if (bus.pending !== 32'h0000_1000) begin fails++; $display("FAIL setclr_set_wins got=%h exp=%h", bus.pending, 32'h0000_1000); end
    tick();
    bus.wr_en = 1'b0;
    #1;
    tests++; if (bus.pending !== 32'h0) begin fails++; $display("FAIL setclr_cleared got=%h exp=%h", bus.pending, 32'h0); end
    idle_inputs();
    tick();
  endtask

  task automatic test_zero_load();
    bus.issue_valid = 1'b1; bus.issue_load = 1'b1; bus.issue_dst = 5'd0;
    tick();
    idle_inputs();
    #1;
    tests++; if (bus.pending !== 32'h0) begin fails++; $display("FAIL r0load_pending got=%h exp=%h", bus.pending, 32'h0); end
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL r0load_stall got=%b exp=%b", bus.stall, 1'b0); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    for (int i = 1; i < 8; i++) begin
      bus.wr_en = 1'b1; bus.wr_addr = 5'(i); bus.wr_data = $urandom | 32'h1;
      tick();
    end
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h3333_3333;
    tick();
    bus.wr_en = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_load = 1'b1; bus.issue_dst = 5'd8;
    tick();
    bus.issue_valid = 1'b0; bus.issue_load = 1'b0;
    bus.rs_addr = 5'd8; bus.rt_addr = 5'd3;
    #1;
    tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL mid_pre_stall got=%b exp=%b", bus.stall, 1'b1); end
    tests++; if (bus.pending !== 32'h0000_0100) begin fails++; $display("FAIL mid_pre_pending got=%h exp=%h", bus.pending, 32'h0000_0100); end
    #1 rst_n = 1'b0;
    #1;
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL mid_stall got=%b exp=%b", bus.stall, 1'b0); end
    tests++; if (bus.pending !== 32'h0) begin fails++; $display("FAIL mid_pending got=%h exp=%h", bus.pending, 32'h0); end
    tests++; if (bus.out1 !== 32'h0) begin fails++; $display("FAIL mid_out1 got=%h exp=%h", bus.out1, 32'h0); end
    tests++; if (bus.out2 !== 32'h0) begin fails++; $display("FAIL mid_out2 got=%h exp=%h", bus.out2, 32'h0); end
    #2 rst_n = 1'b1;
    tick();
    tests++; if (bus.out2 !== 32'h0) begin fails++; $display("FAIL mid_after_release got=%h exp=%h", bus.out2, 32'h0); end
    idle_inputs();
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_load_use();
    test_set_clear();
    test_zero_load();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
